// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the MIPS EX stage: one partial product per cycle,
// WIDTH iterations, returns the low WIDTH bits of OpA*OpB and stalls the pipeline meanwhile.
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Flush,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Stall
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] result_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] acc_sum_s;
    logic             load_s;
    logic             step_s;
    logic             last_s;
    logic             stall_s;

    // Partial-product accumulation for the current iteration (wraps modulo 2^WIDTH).
    always_comb begin
        acc_sum_s = acc_r;
        if (mplier_r[0]) begin
            acc_sum_s = acc_r + mcand_r;
        end else begin
            acc_sum_s = acc_r;
        end
    end

    // Next-state and datapath control; Flush outranks Start in every state.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (Flush) begin
                    state_next_s = ST_IDLE;
                end else if (Start) begin
                    load_s       = 1'b1;
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (Flush) begin
                    state_next_s = ST_IDLE;
                end else begin
                    step_s = 1'b1;
                    if (count_r == LAST_COUNT) begin
                        last_s       = 1'b1;
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_BUSY;
                    end
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Stall covers the whole multiply, including the cycle a new Start is accepted.
    always_comb begin
        stall_s = 1'b0;
        if (!Rst) begin
            stall_s = 1'b0;
        end else begin
            stall_s = (state_r == ST_BUSY) ||
                      ((state_r == ST_IDLE) && Start && !Flush) ||
                      ((state_r == ST_DONE) && Start && !Flush);
        end
    end

    // State, operand shift registers and registered outputs.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_r  <= ST_IDLE;
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
            result_r <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_BUSY);
            done_r  <= (state_next_s == ST_DONE);
            if (load_s) begin
                mcand_r  <= OpA;
                mplier_r <= OpB;
                acc_r    <= {WIDTH{1'b0}};
                count_r  <= {CW{1'b0}};
            end else if (step_s) begin
                acc_r    <= acc_sum_s;
                mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
                mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                count_r  <= count_r + COUNT_ONE;
            end
            if (last_s) begin
                result_r <= acc_sum_s;
            end
        end
    end

    assign Busy   = busy_r;
    assign Done   = done_r;
    assign Result = result_r;
    assign Stall  = stall_s;

endmodule
